// File: rtl/alu_issue_stage.sv
// Two-stage registered ALU front end: S1 captures {op, A, B, tag}, S2 holds the
// computed result and flags until the downstream consumer takes it.
module alu_issue_stage #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_div0,
    output logic             out_illegal,
    output logic [CNT_W-1:0] ops_done
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;

    localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic             s2_adv;

    logic [WIDTH-1:0] y_next;
    logic             div0_next;
    logic             illegal_next;

    // out_ready reaches in_ready combinationally so a full pipe still streams.
    assign s2_adv    = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_adv;
    assign out_valid = s2_valid;

    always_comb begin
        y_next       = '0;
        div0_next    = 1'b0;
        illegal_next = 1'b0;
        case (s1_op)
            OP_ADD: y_next = s1_a + s1_b;
            OP_SUB: y_next = s1_a - s1_b;
            OP_MUL: y_next = s1_a * s1_b;
            OP_DIV: begin
                if (s1_b == '0) begin
                    y_next    = '1;
                    div0_next = 1'b1;
                end else begin
                    y_next = s1_a / s1_b;
                end
            end
            OP_MOD: begin
                if (s1_b == '0) begin
                    y_next    = s1_a;
                    div0_next = 1'b1;
                end else begin
                    y_next = s1_a % s1_b;
                end
            end
            OP_XOR: y_next = s1_a ^ s1_b;
            OP_AND: y_next = s1_a & s1_b;
            OP_OR:  y_next = s1_a | s1_b;
            OP_SHR: y_next = (s1_b >= SHIFT_LIM) ? '0 : (s1_a >> s1_b);
            OP_SHL: y_next = (s1_b >= SHIFT_LIM) ? '0 : (s1_a << s1_b);
            default: illegal_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op  <= in_op;
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_tag <= in_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            out_y       <= '0;
            out_tag     <= '0;
            out_div0    <= 1'b0;
            out_illegal <= 1'b0;
        end else if (s2_adv) begin
            s2_valid    <= 1'b1;
            out_y       <= y_next;
            out_tag     <= s1_tag;
            out_div0    <= div0_next;
            out_illegal <= illegal_next;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ops_done <= '0;
        end else if (s2_valid && out_ready && (ops_done != '1)) begin
            ops_done <= ops_done + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage, checked against a queue-based
// reference model; a second small-counter instance exercises ops_done saturation.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [3:0]  out_tag;
    logic        out_div0;
    logic        out_illegal;
    logic [15:0] ops_done;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_y;
    logic [3:0]  s_out_tag;
    logic        s_out_div0;
    logic        s_out_illegal;
    logic [2:0]  s_ops_done;

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(32), .TAG_W(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_tag(out_tag), .out_div0(out_div0), .out_illegal(out_illegal),
        .ops_done(ops_done)
    );

    alu_issue_stage #(.WIDTH(32), .TAG_W(4), .CNT_W(3)) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_y(s_out_y),
        .out_tag(s_out_tag), .out_div0(s_out_div0), .out_illegal(s_out_illegal),
        .ops_done(s_ops_done)
    );

    typedef struct packed {
        logic [37:0] bits;   // {illegal, div0, tag, y}
        int          cyc;
    } exp_t;

    exp_t        mdl_q[$];
    logic [37:0] out_log[$];
    int          done_m;
    int          cyc;
    int          n_checks;
    int          n_errors;

    task automatic chk_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    function automatic logic [37:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [3:0] tag);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint unsigned r  = 0;
        logic d0 = 1'b0;
        logic il = 1'b0;
        case (op)
            4'd0: r = ua + ub;
            4'd1: r = ua - ub;
            4'd2: r = ua * ub;
            4'd3: if (ub == 0) begin r = 64'hFFFF_FFFF; d0 = 1'b1; end else r = ua / ub;
            4'd4: if (ub == 0) begin r = ua; d0 = 1'b1; end else r = ua % ub;
            4'd5: r = ua ^ ub;
            4'd6: r = ua & ub;
            4'd7: r = ua | ub;
            4'd8: r = (ub >= 32) ? 0 : (ua >> ub);
            4'd9: r = (ub >= 32) ? 0 : (ua << ub);
            default: il = 1'b1;
        endcase
        return {il, d0, tag, r[31:0]};
    endfunction

    // One clock cycle: drive at negedge, check against the model, then advance the model.
    task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag, input logic ordy,
                        output logic acc);
        int   n;
        logic exp_ov;
        logic exp_ir;
        int   sat;
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = ordy;
        #1;
        n      = mdl_q.size();
        exp_ov = (n > 0) && (cyc >= mdl_q[0].cyc + 2);
        exp_ir = (n < 2) || ordy;
        sat    = (done_m > 7) ? 7 : done_m;
        chk_val("out_valid", 64'(out_valid), 64'(exp_ov));
        chk_val("in_ready", 64'(in_ready), 64'(exp_ir));
        chk_val("ops_done", 64'(ops_done), 64'(done_m));
        chk_val("sat_out_valid", 64'(s_out_valid), 64'(exp_ov));
        chk_val("sat_in_ready", 64'(s_in_ready), 64'(exp_ir));
        chk_val("sat_ops_done", 64'(s_ops_done), 64'(sat));
        if (exp_ov) begin
            chk_val("out", 64'({out_illegal, out_div0, out_tag, out_y}), 64'(mdl_q[0].bits));
            chk_val("sat_out", 64'({s_out_illegal, s_out_div0, s_out_tag, s_out_y}),
                    64'(mdl_q[0].bits));
            if (ordy) begin
                out_log.push_back({out_illegal, out_div0, out_tag, out_y});
                void'(mdl_q.pop_front());
                done_m++;
            end
        end
        acc = v && exp_ir;
        if (acc) begin
            e.bits = ref_res(op, a, b, tag);
            e.cyc  = cyc;
            mdl_q.push_back(e);
        end
        cyc++;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic ordy);
        logic acc = 1'b0;
        int   tries = 0;
        while (!acc && tries < 50) begin
            step(1'b1, op, a, b, tag, ordy, acc);
            tries++;
        end
        if (!acc) chk_val("issue_timeout", 64'(tries), 64'(0));
    endtask

    task automatic drain();
        logic acc;
        int   k = 0;
        while (mdl_q.size() > 0 && k < 40) begin
            step(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, acc);
            k++;
        end
        chk_val("drain_left", 64'(mdl_q.size()), 64'(0));
        step(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_val("rst_out_valid", 64'(out_valid), 64'(0));
        chk_val("rst_in_ready", 64'(in_ready), 64'(1));
        chk_val("rst_ops_done", 64'(ops_done), 64'(0));
        chk_val("rst_outputs", 64'({out_illegal, out_div0, out_tag, out_y}), 64'(0));
        mdl_q.delete();
        out_log.delete();
        done_m = 0;
    endtask

    int          t1_y[10] = '{9, 5, 14, 3, 1, 5, 2, 7, 1, 28};
    logic [3:0]  d_op[7]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd12, 4'd9};
    logic [31:0] d_a[7]   = '{32'hFFFF_FFFF, 32'd0, 32'h1_0000, 32'd5, 32'd5, 32'd3, 32'd1};
    logic [31:0] d_b[7]   = '{32'd1, 32'd1, 32'h1_0000, 32'd0, 32'd0, 32'd4, 32'd32};
    logic [31:0] d_y[7]   = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd0};
    logic        d_d0[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        d_il[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        logic acc;
        int   accepted;
        int   budget;
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        done_m    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        do_reset();

        // T1: op stream 0..9 with A=7, B=2
        for (int i = 0; i < 10; i++) issue(4'(i), 32'd7, 32'd2, 4'(i), 1'b1);
        drain();
        chk_val("t1_count", 64'(out_log.size()), 64'(10));
        for (int i = 0; i < 10 && i < out_log.size(); i++)
            chk_val($sformatf("t1_y%0d", i), 64'(out_log[i][31:0]), 64'(t1_y[i]));
        chk_val("t1_ops_done", 64'(ops_done), 64'(10));
        chk_val("t1_sat_ops_done", 64'(s_ops_done), 64'(7));

        // T2/T3: wrap and corner cases
        out_log.delete();
        for (int i = 0; i < 7; i++) issue(d_op[i], d_a[i], d_b[i], 4'(i), 1'b1);
        drain();
        chk_val("t3_count", 64'(out_log.size()), 64'(7));
        for (int i = 0; i < 7 && i < out_log.size(); i++)
            chk_val($sformatf("t3_res%0d", i), 64'(out_log[i]),
                    64'({d_il[i], d_d0[i], 4'(i), d_y[i]}));

        // T4: backpressure with tags 1,2,3
        out_log.delete();
        issue(4'd0, 32'd10, 32'd1, 4'd1, 1'b0);
        issue(4'd0, 32'd20, 32'd2, 4'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'd0, 32'd30, 32'd3, 4'd3, 1'b0, acc);
            chk_val("t4_stall_ready", 64'(in_ready), 64'(0));
            chk_val("t4_frozen_tag", 64'(out_tag), 64'(1));
            chk_val("t4_frozen_y", 64'(out_y), 64'(11));
        end
        issue(4'd0, 32'd30, 32'd3, 4'd3, 1'b1);
        drain();
        chk_val("t4_count", 64'(out_log.size()), 64'(3));
        for (int i = 0; i < 3 && i < out_log.size(); i++)
            chk_val($sformatf("t4_tag%0d", i), 64'(out_log[i][35:32]), 64'(i + 1));

        // T5: 1000 random transactions with random valid/ready
        do_reset();
        accepted = 0;
        budget   = 0;
        while (accepted < 1000 && budget < 20000) begin
            logic [31:0] b;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(0, 40));
                default: b = $urandom;
            endcase
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom, b,
                 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, acc);
            if (acc) accepted++;
            budget++;
        end
        chk_val("t5_accepted", 64'(accepted), 64'(1000));
        drain();
        chk_val("t5_ops_done", 64'(ops_done), 64'(1000));
        chk_val("t5_sat_ops_done", 64'(s_ops_done), 64'(7));

        // T6: reset with both stages full
        issue(4'd0, 32'd1, 32'd1, 4'd5, 1'b0);
        issue(4'd0, 32'd2, 32'd2, 4'd6, 1'b0);
        step(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, acc);
        chk_val("t6_full_ready", 64'(in_ready), 64'(0));
        do_reset();
        issue(4'd1, 32'd9, 32'd4, 4'd7, 1'b1);
        issue(4'd9, 32'd1, 32'd3, 4'd8, 1'b1);
        drain();
        chk_val("t6_count", 64'(out_log.size()), 64'(2));
        for (int i = 0; i < 2 && i < out_log.size(); i++)
            chk_val($sformatf("t6_tag%0d", i), 64'(out_log[i][35:32]), 64'(i + 7));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
